// File: rtl/i2c_slave_rx.sv
// I2C slave receive front-end: bus synchronisation, start/stop detection, address match,
// MSB-first byte capture with ACK/NACK. Optional macro I2C_RX_GLITCH_FILTER_EN adds majority filtering.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000,
  parameter int         MAX_BYTES  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       mode,
  output logic       addr_match,
  output logic [4:0] byte_cnt,
  output logic       start_det,
  output logic       stop_det,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

  logic       scl_m, scl_s, sda_m, sda_s, scl_c, sda_c, scl_q, sda_q;
  logic [2:0] warm;
  logic       sync_ok, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_s;

`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam logic [2:0] WARM_CYCLES = 3'd6;
  logic [1:0] scl_h, sda_h;
  logic       scl_f, sda_f;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s};
      sda_h <= {sda_h[0], sda_s};
      scl_f <= maj3(scl_s, scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_s, sda_h[0], sda_h[1]);
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  localparam logic [2:0] WARM_CYCLES = 3'd3;
  assign scl_c = scl_s;
  assign sda_c = sda_s;
`endif

  // Edge detection stays gated until the pipeline holds real bus samples, so a reset
  // taken mid-transfer cannot fabricate a start/stop from the flops' reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      warm  <= 3'd0;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      sda_m <= sda_in;
      sda_s <= sda_m;
      scl_q <= scl_c;
      sda_q <= sda_c;
      warm  <= (warm == WARM_CYCLES) ? warm : warm + 3'd1;
    end
  end

  assign sync_ok  = (warm == WARM_CYCLES);
  assign scl_rise = sync_ok & scl_c & ~scl_q;
  assign scl_fall = sync_ok & ~scl_c & scl_q;
  assign start_c  = sync_ok & scl_q & sda_q & ~sda_c;
  assign stop_c   = sync_ok & scl_q & ~sda_q & sda_c;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, rx_data_n;
  logic       ack_phase, ack_phase_n, accepted, accepted_n;
  logic       sda_n, valid_n, mode_n, match_n, start_n, stop_n, ovf_n;
  logic [4:0] cnt_n;

  assign byte_s = {shift[6:0], sda_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      ack_phase  <= 1'b0;
      accepted   <= 1'b0;
      sda_out    <= 1'b1;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      mode       <= 1'b0;
      addr_match <= 1'b0;
      byte_cnt   <= 5'd0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      ack_phase  <= ack_phase_n;
      accepted   <= accepted_n;
      sda_out    <= sda_n;
      rx_data    <= rx_data_n;
      rx_valid   <= valid_n;
      mode       <= mode_n;
      addr_match <= match_n;
      byte_cnt   <= cnt_n;
      start_det  <= start_n;
      stop_det   <= stop_n;
      overflow   <= ovf_n;
    end
  end

  // Bus conditions override every state; ACK slots span two scl falling edges.
  always_comb begin
    state_n     = state;
    bit_n       = bit_cnt;
    shift_n     = shift;
    ack_phase_n = ack_phase;
    accepted_n  = accepted;
    sda_n       = sda_out;
    rx_data_n   = rx_data;
    valid_n     = 1'b0;
    mode_n      = mode;
    match_n     = addr_match;
    cnt_n       = byte_cnt;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    ovf_n       = 1'b0;
    if (stop_c) begin
      stop_n  = 1'b1;
      state_n = IDLE;
      sda_n   = 1'b1;
      match_n = 1'b0;
    end else if (start_c) begin
      start_n     = 1'b1;
      bit_n       = 3'd0;
      ack_phase_n = 1'b0;
      match_n     = 1'b0;
      sda_n       = 1'b1;
      state_n     = ADDR;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = byte_s;
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase_n = 1'b0;
              state_n     = (byte_s[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
            end else begin
              state_n = ADDR;
            end
          end else begin
            state_n = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall && !ack_phase) begin
            sda_n       = 1'b0;
            ack_phase_n = 1'b1;
            mode_n      = shift[0];
            match_n     = 1'b1;
            cnt_n       = 5'd0;
          end else if (scl_fall) begin
            sda_n       = 1'b1;
            ack_phase_n = 1'b0;
            bit_n       = 3'd0;
            state_n     = DATA;
          end else begin
            state_n = ADDR_ACK;
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_n = byte_s;
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase_n = 1'b0;
              state_n     = DATA_ACK;
              if (rx_ready && (byte_cnt < MAX_CNT)) begin
                rx_data_n  = byte_s;
                valid_n    = 1'b1;
                cnt_n      = byte_cnt + 5'd1;
                accepted_n = 1'b1;
              end else begin
                ovf_n      = 1'b1;
                accepted_n = 1'b0;
              end
            end else begin
              state_n = DATA;
            end
          end else begin
            state_n = DATA;
          end
        end
        DATA_ACK: begin
          if (scl_fall && !ack_phase) begin
            sda_n       = ~accepted;
            ack_phase_n = 1'b1;
          end else if (scl_fall) begin
            sda_n       = 1'b1;
            ack_phase_n = 1'b0;
            bit_n       = 3'd0;
            state_n     = DATA;
          end else begin
            state_n = DATA_ACK;
          end
        end
        IDLE:    state_n = IDLE;
        IGNORE:  state_n = IGNORE;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
